xbox_mem_bank: RTL and testbench

Responder end of the XBOX accelerator memory interface: holds `NUM_MEMS` independent line-addressed memories that accelerators master through the `xlr_mem_*` signals. It also provides a 32-bit host word port, so SW can preload operands and read back results. The accelerator port always has priority, and a host access to a busy instance is stalled. The block sits between the accelerator and the APB-side host bridge.

---
 rtl/xbox_mem_bank.sv | 101 ++++++++++
 tb/tb_xbox_mem_bank.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbox_mem_bank.sv
// XBOX accelerator memory bank: NUM_MEMS register-built line memories with a
// zero-latency accelerator port and a lower-priority 32-bit host word port.
module xbox_mem_bank #(
    parameter  int unsigned NUM_MEMS           = 1,
    parameter  int unsigned LOG2_LINES_PER_MEM = 4,
    localparam int unsigned SEL_W              = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]     xlr_mem_addr,
    input  logic [NUM_MEMS-1:0][7:0][31:0]                  xlr_mem_wdata,
    input  logic [NUM_MEMS-1:0][31:0]                       xlr_mem_be,
    input  logic [NUM_MEMS-1:0]                             xlr_mem_rd,
    input  logic [NUM_MEMS-1:0]                             xlr_mem_wr,
    output logic [NUM_MEMS-1:0][7:0][31:0]                  xlr_mem_rdata,
    input  logic [SEL_W-1:0]                                host_mem_sel,
    input  logic [LOG2_LINES_PER_MEM-1:0]                   host_mem_addr,
    input  logic [2:0]                                      host_mem_word,
    input  logic [31:0]                                     host_mem_wdata,
    input  logic                                            host_mem_rd,
    input  logic                                            host_mem_wr,
    output logic                                            host_mem_ready,
    output logic [31:0]                                     host_mem_rdata,
    output logic                                            host_mem_rvalid
);

    localparam int unsigned LINES  = 2 ** LOG2_LINES_PER_MEM;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTES  = LINE_W / 8;

    logic [NUM_MEMS-1:0][LINES-1:0][LINE_W-1:0] mem_q, mem_d;
    logic [WORD_W-1:0]                          rdata_q, rdata_d;
    logic                                       rvalid_q, rvalid_d;
    logic                                       sel_busy;
    logic                                       sel_ok;

    // Host is blocked while the accelerator touches the selected instance
    always_comb begin
        sel_busy = 1'b0;
        for (int unsigned i = 0; i < NUM_MEMS; i++) begin
            if (SEL_W'(i) == host_mem_sel) begin
                sel_busy = xlr_mem_rd[i] | xlr_mem_wr[i];
            end
        end
    end

    assign sel_ok         = 32'(host_mem_sel) < NUM_MEMS;
    assign host_mem_ready = (host_mem_rd | host_mem_wr) & ~rst & ~sel_busy & sel_ok;

    // Accelerator reads see the pre-write array contents
    always_comb begin
        xlr_mem_rdata = '0;
        for (int unsigned i = 0; i < NUM_MEMS; i++) begin
            if (xlr_mem_rd[i] && !rst) begin
                xlr_mem_rdata[i] = mem_q[i][xlr_mem_addr[i]];
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        for (int unsigned i = 0; i < NUM_MEMS; i++) begin
            if (xlr_mem_wr[i]) begin
                for (int unsigned b = 0; b < BYTES; b++) begin
                    if (xlr_mem_be[i][b]) begin
                        mem_d[i][xlr_mem_addr[i]][8*b +: 8] = xlr_mem_wdata[i][b/4][8*(b%4) +: 8];
                    end
                end
            end
            // Accepted host access never collides with an accelerator write to the same instance
            if (host_mem_ready && (SEL_W'(i) == host_mem_sel)) begin
                if (host_mem_wr) begin
                    mem_d[i][host_mem_addr][{host_mem_word, 5'd0} +: WORD_W] = host_mem_wdata;
                end else begin
                    rdata_d  = mem_q[i][host_mem_addr][{host_mem_word, 5'd0} +: WORD_W];
                    rvalid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // A reset arriving while a read is in flight suppresses its result immediately
    assign host_mem_rvalid = rvalid_q & ~rst;
    assign host_mem_rdata  = rst ? '0 : rdata_q;

endmodule

// File: tb/tb_xbox_mem_bank.sv
// Bench for xbox_mem_bank: directed literal scenarios followed by random traffic,
// all cycles checked against a word-array model of the memories.
module tb_xbox_mem_bank;

    localparam int unsigned NM    = 3;
    localparam int unsigned LG    = 4;
    localparam int unsigned LINES = 16;
    localparam int unsigned SW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NM-1:0][LG-1:0]     xlr_mem_addr  = '0;
    logic [NM-1:0][7:0][31:0]  xlr_mem_wdata = '0;
    logic [NM-1:0][31:0]       xlr_mem_be    = '0;
    logic [NM-1:0]             xlr_mem_rd    = '0;
    logic [NM-1:0]             xlr_mem_wr    = '0;
    logic [NM-1:0][7:0][31:0]  xlr_mem_rdata;
    logic [SW-1:0]             host_mem_sel   = '0;
    logic [LG-1:0]             host_mem_addr  = '0;
    logic [2:0]                host_mem_word  = '0;
    logic [31:0]               host_mem_wdata = '0;
    logic                      host_mem_rd    = 1'b0;
    logic                      host_mem_wr    = 1'b0;
    logic                      host_mem_ready;
    logic [31:0]               host_mem_rdata;
    logic                      host_mem_rvalid;

    xbox_mem_bank #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(LG)) dut (
        .clk(clk), .rst(rst),
        .xlr_mem_addr(xlr_mem_addr), .xlr_mem_wdata(xlr_mem_wdata), .xlr_mem_be(xlr_mem_be),
        .xlr_mem_rd(xlr_mem_rd), .xlr_mem_wr(xlr_mem_wr), .xlr_mem_rdata(xlr_mem_rdata),
        .host_mem_sel(host_mem_sel), .host_mem_addr(host_mem_addr), .host_mem_word(host_mem_word),
        .host_mem_wdata(host_mem_wdata), .host_mem_rd(host_mem_rd), .host_mem_wr(host_mem_wr),
        .host_mem_ready(host_mem_ready), .host_mem_rdata(host_mem_rdata),
        .host_mem_rvalid(host_mem_rvalid)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every memory as plain words, plus the host read result
    logic [31:0] mm [NM][LINES][8];
    logic [31:0] m_rdata  = '0;
    logic        m_rvalid = 1'b0;

    function automatic logic [255:0] line_of(input int i, input int a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = mm[i][a][w];
        return l;
    endfunction

    function automatic logic host_accept();
        int s;
        s = int'(host_mem_sel);
        if (!(host_mem_rd || host_mem_wr) || rst || s >= int'(NM)) return 1'b0;
        return !(xlr_mem_rd[s] || xlr_mem_wr[s]);
    endfunction

    // Compare outputs mid-cycle, then advance the model to the next edge
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                logic acc;
                int s, ha, hw;
                acc = host_accept();
                for (int i = 0; i < int'(NM); i++)
                    chk("m_xlr_rdata", 256'(xlr_mem_rdata[i]),
                        (xlr_mem_rd[i] && !rst) ? line_of(i, int'(xlr_mem_addr[i])) : 256'h0);
                chk("m_ready", 256'(host_mem_ready), 256'(acc));
                chk("m_rvalid", 256'(host_mem_rvalid), 256'(m_rvalid && !rst));
                chk("m_rdata", 256'(host_mem_rdata), rst ? 256'h0 : 256'(m_rdata));
                if (rst) begin
                    for (int i = 0; i < int'(NM); i++)
                        for (int a = 0; a < int'(LINES); a++)
                            for (int w = 0; w < 8; w++) mm[i][a][w] = '0;
                    m_rvalid = 1'b0;
                    m_rdata  = '0;
                end else begin
                    s  = int'(host_mem_sel);
                    ha = int'(host_mem_addr);
                    hw = int'(host_mem_word);
                    m_rvalid = 1'b0;
                    if (acc && host_mem_rd && !host_mem_wr) begin
                        m_rdata  = mm[s][ha][hw];
                        m_rvalid = 1'b1;
                    end
                    if (acc && host_mem_wr) mm[s][ha][hw] = host_mem_wdata;
                    for (int i = 0; i < int'(NM); i++)
                        if (xlr_mem_wr[i])
                            for (int b = 0; b < 32; b++)
                                if (xlr_mem_be[i][b])
                                    mm[i][int'(xlr_mem_addr[i])][b/4][8*(b%4) +: 8] =
                                        xlr_mem_wdata[i][b/4][8*(b%4) +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        xlr_mem_rd = '0; xlr_mem_wr = '0; xlr_mem_be = '0; xlr_mem_wdata = '0; xlr_mem_addr = '0;
        host_mem_rd = 1'b0; host_mem_wr = 1'b0; host_mem_sel = '0; host_mem_addr = '0;
        host_mem_word = '0; host_mem_wdata = '0;
    endtask

    task automatic host_write(input int sel, input int a, input int w, input logic [31:0] d);
        host_mem_sel = SW'(sel); host_mem_addr = LG'(a); host_mem_word = 3'(w);
        host_mem_wdata = d; host_mem_wr = 1'b1;
        @(negedge clk);
        chk("host_wr_ready", 256'(host_mem_ready), 256'h1);
        tick();
        host_mem_wr = 1'b0;
    endtask

    task automatic xlr_write(input int i, input int a, input logic [255:0] d, input logic [31:0] be);
        xlr_mem_addr[i] = LG'(a); xlr_mem_wdata[i] = d; xlr_mem_be[i] = be; xlr_mem_wr[i] = 1'b1;
        tick();
        xlr_mem_wr[i] = 1'b0;
    endtask

    task automatic xlr_read_chk(input string name, input int i, input int a, input logic [255:0] exp);
        xlr_mem_addr[i] = LG'(a); xlr_mem_rd[i] = 1'b1;
        @(negedge clk);
        chk(name, 256'(xlr_mem_rdata[i]), exp);
        tick();
        xlr_mem_rd[i] = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        tick();
        rst = 1'b0;

        // Reset readout
        for (int a = 0; a < int'(LINES); a++) begin
            xlr_mem_addr[0] = LG'(a); xlr_mem_rd[0] = 1'b1;
            @(negedge clk);
            chk("rst_readout", 256'(xlr_mem_rdata[0]), 256'h0);
            chk("rst_rvalid", 256'(host_mem_rvalid), 256'h0);
            tick();
        end
        idle();

        // Preload and compute round-trip
        for (int w = 0; w < 8; w++) host_write(0, 0, w, 32'(w + 1));
        xlr_read_chk("preload_line", 0, 0,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
        xlr_write(0, 1, {128'h0, 32'd50, 32'd43, 32'd22, 32'd19}, 32'hFFFF_FFFF);
        host_mem_sel = 2'd0; host_mem_addr = 4'd1; host_mem_word = 3'd2; host_mem_rd = 1'b1;
        @(negedge clk);
        chk("host_rd_ready", 256'(host_mem_ready), 256'h1);
        tick();
        host_mem_rd = 1'b0;
        @(negedge clk);
        chk("host_rd_rvalid", 256'(host_mem_rvalid), 256'h1);
        chk("host_rd_data", 256'(host_mem_rdata), 256'd43);
        tick();
        @(negedge clk);
        chk("host_rvalid_pulse", 256'(host_mem_rvalid), 256'h0);
        chk("host_rdata_hold", 256'(host_mem_rdata), 256'd43);
        tick();

        // Byte enables
        xlr_write(0, 2, {256{1'b1}}, 32'hFFFF_FFFF);
        xlr_write(0, 2, 256'h0, 32'h0000_000F);
        xlr_read_chk("byte_enable", 0, 2, {{7{32'hFFFF_FFFF}}, 32'h0});

        // Contention: host write stalls behind three accelerator writes
        host_mem_sel = 2'd0; host_mem_addr = 4'd4; host_mem_word = 3'd0;
        host_mem_wdata = 32'hAAAA_AAAA; host_mem_wr = 1'b1;
        xlr_mem_addr[0] = 4'd4; xlr_mem_wdata[0] = {8{32'h5555_5555}};
        xlr_mem_be[0] = 32'hFFFF_FFFF; xlr_mem_wr[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("contend_stall", 256'(host_mem_ready), 256'h0);
            tick();
        end
        xlr_mem_wr[0] = 1'b0;
        @(negedge clk);
        chk("contend_release", 256'(host_mem_ready), 256'h1);
        tick();
        idle();
        xlr_read_chk("contend_final", 0, 4, {{7{32'h5555_5555}}, 32'hAAAA_AAAA});

        // Same-cycle read/write returns the old line
        xlr_write(0, 3, {8{32'h0A0A_0A0A}}, 32'hFFFF_FFFF);
        xlr_mem_addr[0] = 4'd3; xlr_mem_wdata[0] = {8{32'h0B0B_0B0B}};
        xlr_mem_be[0] = 32'hFFFF_FFFF; xlr_mem_rd[0] = 1'b1; xlr_mem_wr[0] = 1'b1;
        @(negedge clk);
        chk("rw_old", 256'(xlr_mem_rdata[0]), {8{32'h0A0A_0A0A}});
        tick();
        xlr_mem_wr[0] = 1'b0;
        @(negedge clk);
        chk("rw_new", 256'(xlr_mem_rdata[0]), {8{32'h0B0B_0B0B}});
        tick();
        idle();

        // Independence: host on instance 1 while accelerator writes instance 0
        xlr_mem_addr[0] = 4'd5; xlr_mem_be[0] = 32'hFFFF_FFFF; xlr_mem_wr[0] = 1'b1;
        host_write(1, 5, 7, 32'h1234_5678);
        idle();
        xlr_read_chk("indep_inst1", 1, 5, {32'h1234_5678, 224'h0});

        // Out-of-range select is never accepted
        host_mem_sel = 2'd3; host_mem_addr = 4'd0; host_mem_word = 3'd0;
        host_mem_wdata = 32'hDEAD_BEEF; host_mem_wr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("oor_ready", 256'(host_mem_ready), 256'h0);
            tick();
        end
        idle();
        xlr_read_chk("oor_no_effect", 0, 0,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);

        // Mid-read reset drops the pending result and clears the array
        host_mem_sel = 2'd0; host_mem_addr = 4'd1; host_mem_word = 3'd2; host_mem_rd = 1'b1;
        @(negedge clk);
        chk("midrst_accept", 256'(host_mem_ready), 256'h1);
        tick();
        host_mem_rd = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rvalid", 256'(host_mem_rvalid), 256'h0);
        chk("midrst_rdata", 256'(host_mem_rdata), 256'h0);
        tick();
        rst = 1'b0;
        for (int a = 0; a < int'(LINES); a++) begin
            xlr_mem_rd = '1;
            for (int i = 0; i < int'(NM); i++) xlr_mem_addr[i] = LG'(a);
            @(negedge clk);
            for (int i = 0; i < int'(NM); i++) chk("midrst_cleared", 256'(xlr_mem_rdata[i]), 256'h0);
            chk("midrst_no_rvalid", 256'(host_mem_rvalid), 256'h0);
            tick();
        end
        idle();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(NM); i++) begin
                xlr_mem_rd[i]    = ($urandom_range(0, 3) == 0);
                xlr_mem_wr[i]    = ($urandom_range(0, 3) == 0);
                xlr_mem_addr[i]  = LG'($urandom_range(0, LINES - 1));
                for (int w = 0; w < 8; w++) xlr_mem_wdata[i][w] = $urandom;
                xlr_mem_be[i]    = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            end
            host_mem_rd    = ($urandom_range(0, 1) == 0);
            host_mem_wr    = ($urandom_range(0, 2) == 0);
            host_mem_sel   = SW'($urandom_range(0, 3));
            host_mem_addr  = LG'($urandom_range(0, LINES - 1));
            host_mem_word  = 3'($urandom_range(0, 7));
            host_mem_wdata = $urandom;
            rst            = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
